// File: rtl/radix3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : radix3_pkg
//  Purpose  : Shared constants for the radix-3 inverse butterfly: the
//             sqrt(3)/2 coefficient and word-growth figures per stage.
//  Revision : 1.0  initial release
// ============================================================================
package radix3_pkg;

    // Width of the sqrt(3)/2 coefficient, unsigned Q1.(KW-1)
    localparam int KW = 16;

    // sqrt(3)/2 in Q1.15 (0.86602... * 32768 = 28377.9 -> 28378)
    localparam logic [KW-1:0] K_SQRT3_2 = 16'd28378;

    // b+c / b-c grow by one bit; the full-precision outputs grow by two
    localparam int SUM_GROWTH = 1;
    localparam int OUT_GROWTH = 2;

endpackage
`default_nettype wire

// File: rtl/radix3_const_mult.sv
`default_nettype none
// ============================================================================
//  Module   : radix3_const_mult
//  Purpose  : Multiplies a signed (DW+1)-bit operand by the unsigned
//             Q1.(KW-1) constant K and returns the product rounded half-up
//             back to integer scale: (d*K + 2^(KW-2)) >>> (KW-1).
//  Revision : 1.0  initial release
// ============================================================================
module radix3_const_mult
    import radix3_pkg::*;
#(
    parameter int              DW = 16,
    parameter int              KW = radix3_pkg::KW,
    parameter logic [KW-1:0]   K  = radix3_pkg::K_SQRT3_2
) (
    input  logic signed [DW:0] i_d,
    output logic signed [DW:0] o_m
);

    // Product width: signed operand plus a zero-extended (hence signed) K
    localparam int PW = DW + KW + 2;

    localparam logic signed [PW-1:0] C_HALF = PW'(1) <<< (KW - 2);
    localparam logic signed [PW-1:0] C_K    = PW'($signed({1'b0, K}));

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_rnd;

    // Full-precision product, half-up rounding offset, then drop the fraction
    always_comb begin
        w_prod = PW'(i_d) * C_K;
        w_rnd  = w_prod + C_HALF;
        o_m    = (DW + 1)'(w_rnd >>> (KW - 1));
    end

endmodule
`default_nettype wire

// File: rtl/radix_3_ifft.sv
`default_nettype none
// ============================================================================
//  Module   : radix_3_ifft
//  Purpose  : Streaming radix-3 inverse butterfly, one complex triplet per
//             clock. Three register stages under a single global stall
//             enable (en = !out_valid | out_ready).
//  Config   : RADIX3_IFFT_SCALE_EN - outputs rounded divide-by-4, OW = DW.
//             Undefined (default)   - full-precision outputs, OW = DW+2.
//  Revision : 1.0  initial release
// ============================================================================
module radix_3_ifft
    import radix3_pkg::*;
#(
    parameter int DW = 16,
    parameter int KW = radix3_pkg::KW,
`ifdef RADIX3_IFFT_SCALE_EN
    localparam int OW = DW
`else
    localparam int OW = DW + 2
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_img,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_img,
    input  logic signed [DW-1:0] c_re,
    input  logic signed [DW-1:0] c_img,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic signed [OW-1:0] x0_re,
    output logic signed [OW-1:0] x0_img,
    output logic signed [OW-1:0] x1_re,
    output logic signed [OW-1:0] x1_img,
    output logic signed [OW-1:0] x2_re,
    output logic signed [OW-1:0] x2_img
);

    localparam int SW = DW + SUM_GROWTH;   // s, d, m
    localparam int FW = DW + OUT_GROWTH;   // x0, t, x1, x2 before output scaling

    logic                 w_en;
    logic                 r_v1, r_l1, r_v2, r_l2;
    logic signed [DW-1:0] r_a_re, r_a_img;
    logic signed [SW-1:0] r_s_re, r_s_img, r_d_re, r_d_img;
    logic signed [SW-1:0] w_m_re, w_m_img, r_m_re, r_m_img;
    logic signed [FW-1:0] r_x0_re, r_x0_img, r_t_re, r_t_img;

    // Output formatting: rounded divide by 4 when scaling, else pass-through
    function automatic logic signed [OW-1:0] f_out(input logic signed [FW-1:0] v);
`ifdef RADIX3_IFFT_SCALE_EN
        return OW'((v + FW'(2)) >>> 2);
`else
        return v;
`endif
    endfunction

    // One enable for every stage keeps the pipeline bubble-free and lossless
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Stage-1/2 control: valid and last travel together with their triplet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
            r_v2 <= 1'b0;
            r_l2 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_l1 <= in_valid && in_last;
            r_v2 <= r_v1;
            r_l2 <= r_l1;
        end
    end

    // Stage 1: sum and difference of b and c at full precision, a delayed
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_a_re  <= a_re;
            r_a_img <= a_img;
            r_s_re  <= SW'(b_re)  + SW'(c_re);
            r_s_img <= SW'(b_img) + SW'(c_img);
            r_d_re  <= SW'(b_re)  - SW'(c_re);
            r_d_img <= SW'(b_img) - SW'(c_img);
        end
    end

    radix3_const_mult #(.DW(DW), .KW(KW), .K(KW'(K_SQRT3_2))) u_mult_re (
        .i_d (r_d_re),
        .o_m (w_m_re)
    );

    radix3_const_mult #(.DW(DW), .KW(KW), .K(KW'(K_SQRT3_2))) u_mult_img (
        .i_d (r_d_img),
        .o_m (w_m_img)
    );

    // Stage 2: X0, the shared real-part term t = a - s/2 (floor), and m = K*d
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_x0_re  <= FW'(r_a_re)  + FW'(r_s_re);
            r_x0_img <= FW'(r_a_img) + FW'(r_s_img);
            r_t_re   <= FW'(r_a_re)  - FW'(r_s_re  >>> 1);
            r_t_img  <= FW'(r_a_img) - FW'(r_s_img >>> 1);
            r_m_re   <= w_m_re;
            r_m_img  <= w_m_img;
        end
    end

    // Stage 3: rotate m by +j / -j onto t, register outputs (held while stalled)
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            x0_re     <= '0;
            x0_img    <= '0;
            x1_re     <= '0;
            x1_img    <= '0;
            x2_re     <= '0;
            x2_img    <= '0;
        end else if (w_en) begin
            out_valid <= r_v2;
            out_last  <= r_l2;
            x0_re     <= f_out(r_x0_re);
            x0_img    <= f_out(r_x0_img);
            x1_re     <= f_out(r_t_re  - FW'(r_m_img));
            x1_img    <= f_out(r_t_img + FW'(r_m_re));
            x2_re     <= f_out(r_t_re  + FW'(r_m_img));
            x2_img    <= f_out(r_t_img - FW'(r_m_re));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_radix_3_ifft.sv
`default_nettype none
// ============================================================================
//  Module   : tb_radix_3_ifft
//  Purpose  : Self-checking bench for radix_3_ifft. A queue-based model of
//             the 3-point IDFT follows every accepted triplet; directed
//             vectors with literal results anchor the model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_radix_3_ifft;

    localparam int DW = 16;
`ifdef RADIX3_IFFT_SCALE_EN
    localparam int OW     = DW;
    localparam bit SCALED = 1'b1;
`else
    localparam int OW     = DW + 2;
    localparam bit SCALED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic signed [DW-1:0] a_re, a_img, b_re, b_img, c_re, c_img;
    logic signed [OW-1:0] x0_re, x0_img, x1_re, x1_img, x2_re, x2_img;

    int vectors     = 0;
    int miscompares = 0;
    int stall_cnt   = 0;

    typedef struct {
        longint x0r, x0i, x1r, x1i, x2r, x2i;
        bit     last;
    } exp_t;

    exp_t q[$];

    radix_3_ifft dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img),
        .c_re(c_re), .c_img(c_img),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .x0_re(x0_re), .x0_img(x0_img), .x1_re(x1_re), .x1_img(x1_img),
        .x2_re(x2_re), .x2_img(x2_img)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor division on integers
    function automatic longint fdiv(input longint n, input longint d);
        longint r;
        r = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0))) r = r - 1;
        return r;
    endfunction

    function automatic longint sc(input longint v);
        return SCALED ? fdiv(v + 2, 4) : v;
    endfunction

    // X0 = a+b+c; X1/X2 = a - (b+c)/2 +/- j*(sqrt3/2)*(b-c), with /2 floored
    // and the sqrt3/2 product rounded half-up in Q1.15
    function automatic exp_t model(input longint ar, ai, br, bi, cr, ci, input bit last);
        exp_t   e;
        longint sr, si, dr, di, tr, ti, mr, mi;
        sr = br + cr;  si = bi + ci;
        dr = br - cr;  di = bi - ci;
        tr = ar - fdiv(sr, 2);
        ti = ai - fdiv(si, 2);
        mr = fdiv(dr * 28378 + 16384, 32768);
        mi = fdiv(di * 28378 + 16384, 32768);
        e.x0r = sc(ar + sr);  e.x0i = sc(ai + si);
        e.x1r = sc(tr - mi);  e.x1i = sc(ti + mr);
        e.x2r = sc(tr + mi);  e.x2i = sc(ti - mr);
        e.last = last;
        return e;
    endfunction

    // Compare process: mid-cycle view of what the next rising edge will do
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            check("in_ready_rule", in_ready, (!out_valid || out_ready));
            if (out_valid && !out_ready && !in_ready) stall_cnt++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = q[0];
                    check("x0_re", x0_re, e.x0r);  check("x0_img", x0_img, e.x0i);
                    check("x1_re", x1_re, e.x1r);  check("x1_img", x1_img, e.x1i);
                    check("x2_re", x2_re, e.x2r);  check("x2_img", x2_img, e.x2i);
                    check("out_last", out_last, e.last);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(a_re, a_img, b_re, b_img, c_re, c_img, in_last));
        end
    end

    // Present one triplet and hold it until accepted; returns 1ns after that edge
    task automatic send(input int ar, ai, br, bi, cr, ci, input bit last);
        bit took = 1'b0;
        int guard = 0;
        a_re = DW'(ar);  a_img = DW'(ai);
        b_re = DW'(br);  b_img = DW'(bi);
        c_re = DW'(cr);  c_img = DW'(ci);
        in_last  = last;
        in_valid = 1'b1;
        while (!took && guard < 100) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!took) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    // Single triplet with literal expectations; out_valid must rise 3 clocks later
    task automatic single_lit(input string tag, input int ar, ai, br, bi, cr, ci,
                              input longint e0r, e0i, e1r, e1i, e2r, e2i, input bit raw);
        send(ar, ai, br, bi, cr, ci, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check({tag, "_valid_latency"}, out_valid, (k == 3));
        end
        check({tag, "_x0_re"},  x0_re,  raw ? e0r : sc(e0r));
        check({tag, "_x0_img"}, x0_img, raw ? e0i : sc(e0i));
        check({tag, "_x1_re"},  x1_re,  raw ? e1r : sc(e1r));
        check({tag, "_x1_img"}, x1_img, raw ? e1i : sc(e1i));
        check({tag, "_x2_re"},  x2_re,  raw ? e2r : sc(e2r));
        check({tag, "_x2_img"}, x2_img, raw ? e2i : sc(e2i));
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_x0_re"},  x0_re,  0);  check({tag, "_x0_img"}, x0_img, 0);
        check({tag, "_x1_re"},  x1_re,  0);  check({tag, "_x1_img"}, x1_img, 0);
        check({tag, "_x2_re"},  x2_re,  0);  check({tag, "_x2_img"}, x2_img, 0);
    endtask

    int tv [8][6] = '{
        '{ 32767,  32767,  32767,  32767,  32767,  32767},
        '{-32768, -32768, -32768, -32768, -32768, -32768},
        '{     0,      0,  32767, -32768, -32768,  32767},
        '{-32768,  32767,  32767, -32768,      0,      0},
        '{     1,     -1,      3,      5,     -7,      2},
        '{    -3,      0,      1,      0,      0,      1},
        '{ 12345,  -2222, -30000,     17,  29999, -32768},
        '{     0,      0,     -1,     -1,      1,      1}
    };

    logic [15:0] ready_pat = 16'b1011_0011_1000_1101;

    initial begin
        rst = 1'b1;  in_valid = 1'b0;  in_last = 1'b0;  out_ready = 1'b1;
        a_re = '0;  a_img = '0;  b_re = '0;  b_img = '0;  c_re = '0;  c_img = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1;

        single_lit("t1", 100, 0, 0, 0, 0, 0,       100, 0, 100, 0, 100, 0, 1'b0);
        single_lit("t2", 0, 0, 1000, 0, 0, 0,      1000, 0, -500, 866, -500, -866, 1'b0);
        single_lit("t3", 1000, -1000, 1000, -1000, 1000, -1000,
                   3000, -3000, 0, 0, 0, 0, 1'b0);

        // Six-triplet frame with a 5-cycle downstream stall mid-stream
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(100 * i, -7 * i, 2000 - i, 3 * i, -500 + 11 * i, 250, (i == 5));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("t4_stall_cycles", stall_cnt, 5);

        // Reset with triplets in flight, then a fresh triplet
        send(1234, -99, 500, 600, -700, 800, 1'b0);
        send(-321, 77, 10, 20, 30, 40, 1'b0);
        send(5, 6, 7, 8, 9, 10, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cleared("t5_after_rst");
        @(posedge clk);
        #1;
        single_lit("t5_fresh", 0, 0, 0, 1000, 0, 0, 0, 1000, -866, -500, 866, -500, 1'b0);

        // Full-scale corners under an irregular out_ready pattern
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5], (i == 7));
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    out_ready = ready_pat[c % 16];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef RADIX3_IFFT_SCALE_EN
        single_lit("t6", 32767, -32768, 32767, -32768, 32767, -32768,
                   24575, -24576, 0, 0, 0, 0, 1'b1);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
